// File: rtl/sw_debounce_sched_if.sv
// Event FIFO handshake: the debouncer presents the head event code, the consumer acknowledges to pop it.
// No latency of its own; the consumer applies backpressure by holding EVT_ACK low.
interface sw_debounce_sched_if;
    logic       EVT_VALID;
    logic [2:0] EVT_CODE;
    logic       EVT_ACK;

    modport master (output EVT_VALID, output EVT_CODE, input EVT_ACK);
    modport slave  (input EVT_VALID, input EVT_CODE, output EVT_ACK);
endinterface

// File: rtl/sw_debounce_sched.sv
// Four-switch debouncer: one comparator is time-shared over a scan that runs once per TICK. Each accepted level change is queued in a 4-entry event FIFO.
// SW_OUT[i] updates at TICK cycle + 2 + i. Events are held until EVT_ACK; a push into a full FIFO is dropped and sets OVERFLOW.
module sw_debounce_sched #(
    parameter int TICK_DIV   = 500000,
    parameter int STABLE_CNT = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [3:0]                 SW_IN,
    output logic [3:0]                 SW_OUT,
    output logic [3:0]                 PRESS,
    output logic                       OVERFLOW,
    output logic                       TICK,
    sw_debounce_sched_if.master        evt
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [1:0]      CNT_LAST  = 2'(STABLE_CNT - 1);

    typedef enum logic [2:0] {IDLE, SCAN0, SCAN1, SCAN2, SCAN3} state_t;

    logic [PW-1:0]   presc;
    logic [3:0]      sync1, sync2;
    state_t          state, state_nxt;
    logic            scan_en;
    logic [1:0]      scan_idx;
    logic [3:0][1:0] cnt;
    logic [1:0]      cnt_cur;
    logic            samp, differ, accept;

    logic [3:0][2:0] mem;
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      count;
    logic            evt_valid, push, pop, full, push_ok;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            presc <= '0;
        else if (presc == PRESC_MAX)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    assign TICK = (presc == PRESC_MAX);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW_IN;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scan_en   = 1'b0;
        scan_idx  = 2'd0;
        case (state)
            IDLE:    if (TICK) state_nxt = SCAN0;
            SCAN0:   begin state_nxt = SCAN1; scan_en = 1'b1; scan_idx = 2'd0; end
            SCAN1:   begin state_nxt = SCAN2; scan_en = 1'b1; scan_idx = 2'd1; end
            SCAN2:   begin state_nxt = SCAN3; scan_en = 1'b1; scan_idx = 2'd2; end
            SCAN3:   begin state_nxt = IDLE;  scan_en = 1'b1; scan_idx = 2'd3; end
            default: state_nxt = IDLE;
        endcase
    end

    // Single comparator, steered to the switch selected by the scan state
    assign samp    = sync2[scan_idx];
    assign cnt_cur = cnt[scan_idx];
    assign differ  = scan_en && (samp != SW_OUT[scan_idx]);
    assign accept  = differ && (cnt_cur == CNT_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt    <= '0;
            SW_OUT <= '0;
            PRESS  <= '0;
        end else begin
            PRESS <= '0;
            if (scan_en) begin
                if (!differ || accept)
                    cnt[scan_idx] <= 2'd0;
                else
                    cnt[scan_idx] <= cnt_cur + 2'd1;
                if (accept) begin
                    SW_OUT[scan_idx] <= samp;
                    PRESS[scan_idx]  <= samp;
                end
            end
        end
    end

    assign evt_valid = (count != 3'd0);
    assign full      = (count == 3'd4);
    assign push      = accept;
    assign pop       = evt_valid && evt.EVT_ACK;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {samp, scan_idx};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            if (push && full && !pop)
                OVERFLOW <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign evt.EVT_VALID = evt_valid;
    assign evt.EVT_CODE  = evt_valid ? mem[rd_ptr] : 3'd0;

endmodule
